// File: rtl/registro_pkg.sv
// Shared definitions for the parametrised universal register: operation codes
// and the transmit FSM state encoding.
package registro_pkg;

   localparam logic [2:0] MODO_HOLD  = 3'b000;
   localparam logic [2:0] MODO_SHIFT = 3'b001;
   localparam logic [2:0] MODO_ROT   = 3'b010;
   localparam logic [2:0] MODO_LOAD  = 3'b011;
   localparam logic [2:0] MODO_ASH   = 3'b100;
   localparam logic [2:0] MODO_TX    = 3'b101;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_TX   = 1'b1
   } state_t;

endpackage

// File: rtl/registro_tx_ctrl.sv
// Transmit controller: IDLE/TX FSM, bit counter, latched direction and BUSY/DONE.
// Presents the effective operation and shift direction to the datapath.
module registro_tx_ctrl
   import registro_pkg::*;
#(
   parameter int N = 4
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       enb_i,
   input  logic [2:0] modo_i,
   input  logic       dir_i,
   output logic [2:0] op_o,
   output logic       dir_o,
   output logic       busy_o,
   output logic       done_o
);

   localparam int CW = $clog2(N + 1);

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            dir_q, dir_d;
   logic            done_q, done_d;

   // In TX the datapath is forced into a logical shift along the latched direction.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dir_d   = dir_q;
      done_d  = 1'b0;
      op_o    = modo_i;
      dir_o   = dir_i;
      case (state_q)
         ST_IDLE: begin
            if (enb_i && (modo_i == MODO_TX)) begin
               state_d = ST_TX;
               cnt_d   = CW'(N);
               dir_d   = dir_i;
            end
         end
         ST_TX: begin
            op_o  = MODO_SHIFT;
            dir_o = dir_q;
            if (enb_i) begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - CW'(1);
               end
               if (cnt_q == CW'(1)) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         dir_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dir_q   <= dir_d;
         done_q  <= done_d;
      end
   end

   assign busy_o = (state_q == ST_TX);
   assign done_o = done_q;

endmodule

// File: rtl/registro_univ_param.sv
// Parametrised universal shift register with logical/arithmetic shifts, rotate,
// parallel load and an autonomous serial-transmit mode.
module registro_univ_param
   import registro_pkg::*;
#(
   parameter int           N         = 4,
   parameter logic [N-1:0] RESET_VAL = '0
) (
   input  logic         CLK,
   input  logic         RESET_L,
   input  logic         ENB,
   input  logic [2:0]   MODO,
   input  logic         DIR,
   input  logic         S_IN,
   input  logic [N-1:0] D,
   output logic [N-1:0] Q,
   output logic         S_OUT,
   output logic         BUSY,
   output logic         DONE
);

   logic [N-1:0] q_q, q_d;
   logic [2:0]   opEff;
   logic         dirEff;

   registro_tx_ctrl #(.N(N)) u_ctrl (
      .clk_i  (CLK),
      .rst_ni (RESET_L),
      .enb_i  (ENB),
      .modo_i (MODO),
      .dir_i  (DIR),
      .op_o   (opEff),
      .dir_o  (dirEff),
      .busy_o (BUSY),
      .done_o (DONE)
   );

   // Reserved codes fall into the default and hold the register.
   always_comb begin
      q_d = q_q;
      if (ENB) begin
         case (opEff)
            MODO_SHIFT: q_d = dirEff ? {q_q[N-2:0], S_IN} : {S_IN, q_q[N-1:1]};
            MODO_ROT:   q_d = dirEff ? {q_q[N-2:0], q_q[N-1]} : {q_q[0], q_q[N-1:1]};
            MODO_LOAD:  q_d = D;
            MODO_ASH:   q_d = dirEff ? {q_q[N-2:0], 1'b0} : {q_q[N-1], q_q[N-1:1]};
            MODO_TX:    q_d = D;
            default:    q_d = q_q;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RESET_L) begin
      if (!RESET_L) begin
         q_q <= RESET_VAL;
      end else begin
         q_q <= q_d;
      end
   end

   assign Q     = q_q;
   assign S_OUT = dirEff ? q_q[N-1] : q_q[0];

endmodule

// File: tb/tb_registro_univ_param.sv
// Directed self-checking bench for registro_univ_param with N = 4, RESET_VAL = 0.
module tb_registro_univ_param;

   logic       CLK;
   logic       RESET_L;
   logic       ENB;
   logic [2:0] MODO;
   logic       DIR;
   logic       S_IN;
   logic [3:0] D;
   logic [3:0] Q;
   logic       S_OUT;
   logic       BUSY;
   logic       DONE;

   int nChecks = 0;
   int nFails  = 0;

   registro_univ_param #(.N(4), .RESET_VAL(4'b0000)) dut (
      .CLK     (CLK),
      .RESET_L (RESET_L),
      .ENB     (ENB),
      .MODO    (MODO),
      .DIR     (DIR),
      .S_IN    (S_IN),
      .D       (D),
      .Q       (Q),
      .S_OUT   (S_OUT),
      .BUSY    (BUSY),
      .DONE    (DONE)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Advance one rising edge and settle so outputs reflect that edge.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      RESET_L = 1'b0; ENB = 1'b1; MODO = 3'b000; DIR = 1'b0; S_IN = 1'b0; D = 4'b0000;
      #12;
      RESET_L = 1'b1;
      nChecks++;
      if (Q !== 4'b0000) begin nFails++; $display("[TB] FAIL reset_q: Q=%b expected 0000", Q); end
      nChecks++;
      if (BUSY !== 1'b0 || DONE !== 1'b0) begin nFails++; $display("[TB] FAIL reset_flags: BUSY=%b DONE=%b expected 0 0", BUSY, DONE); end
      MODO = 3'b011; D = 4'b1010;
      tick();
      MODO = 3'b000;
      nChecks++;
      if (Q !== 4'b1010) begin nFails++; $display("[TB] FAIL preload: Q=%b expected 1010", Q); end
      #3;
      RESET_L = 1'b0;
      #1;
      nChecks++;
      if (Q !== 4'b0000 || BUSY !== 1'b0) begin nFails++; $display("[TB] FAIL async_reset: Q=%b BUSY=%b expected 0000 0", Q, BUSY); end
      #1;
      RESET_L = 1'b1;
      tick();
   endtask

   task automatic test_load_rotate();
      MODO = 3'b011; D = 4'b1011;
      tick();
      nChecks++;
      if (Q !== 4'b1011) begin nFails++; $display("[TB] FAIL load: Q=%b expected 1011", Q); end
      MODO = 3'b010; DIR = 1'b0;
      tick();
      nChecks++;
      if (Q !== 4'b1101) begin nFails++; $display("[TB] FAIL rot_right: Q=%b expected 1101", Q); end
      DIR = 1'b1;
      tick();
      nChecks++;
      if (Q !== 4'b1011) begin nFails++; $display("[TB] FAIL rot_left: Q=%b expected 1011", Q); end
      MODO = 3'b110;
      tick();
      MODO = 3'b111;
      tick();
      nChecks++;
      if (Q !== 4'b1011) begin nFails++; $display("[TB] FAIL reserved_hold: Q=%b expected 1011", Q); end
      MODO = 3'b000;
   endtask

   task automatic test_shift();
      logic [3:0] expQ [4] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111};
      logic       expS [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      MODO = 3'b011; D = 4'b0000;
      tick();
      MODO = 3'b001; DIR = 1'b0; S_IN = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         nChecks++;
         if (Q !== expQ[i] || S_OUT !== expS[i]) begin
            nFails++;
            $display("[TB] FAIL shr_%0d: Q=%b S_OUT=%b expected %b %b", i, Q, S_OUT, expQ[i], expS[i]);
         end
      end
      DIR = 1'b1; S_IN = 1'b0;
      tick();
      nChecks++;
      if (Q !== 4'b1110 || S_OUT !== 1'b1) begin nFails++; $display("[TB] FAIL shl: Q=%b S_OUT=%b expected 1110 1", Q, S_OUT); end
      MODO = 3'b000;
   endtask

   task automatic test_arith();
      MODO = 3'b011; D = 4'b1000;
      tick();
      MODO = 3'b100; DIR = 1'b0;
      tick();
      nChecks++;
      if (Q !== 4'b1100) begin nFails++; $display("[TB] FAIL asr_1: Q=%b expected 1100", Q); end
      tick();
      nChecks++;
      if (Q !== 4'b1110) begin nFails++; $display("[TB] FAIL asr_2: Q=%b expected 1110", Q); end
      MODO = 3'b011; D = 4'b0111;
      tick();
      MODO = 3'b100; DIR = 1'b1; S_IN = 1'b1;
      tick();
      nChecks++;
      if (Q !== 4'b1110) begin nFails++; $display("[TB] FAIL asl_1: Q=%b expected 1110", Q); end
      tick();
      nChecks++;
      if (Q !== 4'b1100) begin nFails++; $display("[TB] FAIL asl_2: Q=%b expected 1100", Q); end
      MODO = 3'b000; S_IN = 1'b0;
   endtask

   task automatic test_transmit();
      logic expR [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      logic expL [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      MODO = 3'b101; D = 4'b0110; DIR = 1'b0; S_IN = 1'b0;
      tick();
      MODO = 3'b011; D = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         nChecks++;
         if (BUSY !== 1'b1 || DONE !== 1'b0 || S_OUT !== expR[i]) begin
            nFails++;
            $display("[TB] FAIL txr_bit%0d: BUSY=%b DONE=%b S_OUT=%b expected 1 0 %b", i, BUSY, DONE, S_OUT, expR[i]);
         end
         tick();
      end
      nChecks++;
      if (BUSY !== 1'b0 || DONE !== 1'b1 || Q !== 4'b0000) begin
         nFails++;
         $display("[TB] FAIL txr_done: BUSY=%b DONE=%b Q=%b expected 0 1 0000", BUSY, DONE, Q);
      end
      MODO = 3'b101; D = 4'b1001; DIR = 1'b1;
      tick();
      MODO = 3'b000; DIR = 1'b0;
      nChecks++;
      if (BUSY !== 1'b1 || DONE !== 1'b0 || Q !== 4'b1001) begin
         nFails++;
         $display("[TB] FAIL b2b_start: BUSY=%b DONE=%b Q=%b expected 1 0 1001", BUSY, DONE, Q);
      end
      for (int i = 0; i < 4; i++) begin
         nChecks++;
         if (BUSY !== 1'b1 || S_OUT !== expL[i]) begin
            nFails++;
            $display("[TB] FAIL txl_bit%0d: BUSY=%b S_OUT=%b expected 1 %b", i, BUSY, S_OUT, expL[i]);
         end
         tick();
      end
      nChecks++;
      if (BUSY !== 1'b0 || DONE !== 1'b1 || Q !== 4'b0000) begin
         nFails++;
         $display("[TB] FAIL txl_done: BUSY=%b DONE=%b Q=%b expected 0 1 0000", BUSY, DONE, Q);
      end
      tick();
      nChecks++;
      if (DONE !== 1'b0) begin nFails++; $display("[TB] FAIL done_pulse: DONE=%b expected 0", DONE); end
   endtask

   task automatic test_enable_freeze();
      MODO = 3'b101; D = 4'b0110; DIR = 1'b0; S_IN = 1'b0;
      tick();
      MODO = 3'b000;
      tick();
      ENB = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         nChecks++;
         if (BUSY !== 1'b1 || S_OUT !== 1'b1 || Q !== 4'b0011 || DONE !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL freeze_%0d: BUSY=%b S_OUT=%b Q=%b DONE=%b expected 1 1 0011 0", i, BUSY, S_OUT, Q, DONE);
         end
      end
      ENB = 1'b1;
      tick();
      nChecks++;
      if (BUSY !== 1'b1 || S_OUT !== 1'b1 || Q !== 4'b0001) begin
         nFails++;
         $display("[TB] FAIL resume_bit2: BUSY=%b S_OUT=%b Q=%b expected 1 1 0001", BUSY, S_OUT, Q);
      end
      tick();
      nChecks++;
      if (BUSY !== 1'b1 || S_OUT !== 1'b0 || DONE !== 1'b0) begin
         nFails++;
         $display("[TB] FAIL resume_bit3: BUSY=%b S_OUT=%b DONE=%b expected 1 0 0", BUSY, S_OUT, DONE);
      end
      tick();
      nChecks++;
      if (BUSY !== 1'b0 || DONE !== 1'b1) begin nFails++; $display("[TB] FAIL resume_done: BUSY=%b DONE=%b expected 0 1", BUSY, DONE); end
      tick();
   endtask

   task automatic test_reset_abort();
      MODO = 3'b101; D = 4'b0110; DIR = 1'b0; S_IN = 1'b0;
      tick();
      MODO = 3'b000;
      tick();
      tick();
      #3;
      RESET_L = 1'b0;
      #1;
      nChecks++;
      if (BUSY !== 1'b0 || DONE !== 1'b0 || Q !== 4'b0000) begin
         nFails++;
         $display("[TB] FAIL abort: BUSY=%b DONE=%b Q=%b expected 0 0 0000", BUSY, DONE, Q);
      end
      #1;
      RESET_L = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         nChecks++;
         if (BUSY !== 1'b0 || DONE !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL abort_after_%0d: BUSY=%b DONE=%b expected 0 0", i, BUSY, DONE);
         end
      end
   endtask

   initial begin
      test_reset();
      test_load_rotate();
      test_shift();
      test_arith();
      test_transmit();
      test_enable_freeze();
      test_reset_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
